// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among N_REQ requesters.
// Operands are registered toward the adder and the result is captured into a per-requester response slot.
module adder_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ-1:0]       req_cin,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [N_REQ*WIDTH-1:0] rsp_sum,
   output logic [N_REQ-1:0]       rsp_cout,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   output logic                   add_cin,
   input  logic [WIDTH-1:0]       add_s,
   input  logic                   add_cout,
   output logic                   busy
);
   localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state_q;
   logic [IDXW-1:0]  ptr_q;
   logic [IDXW-1:0]  owner_q;
   logic [N_REQ-1:0] rsp_valid_q;
   logic [N_REQ-1:0] rsp_valid_d;
   logic [N_REQ-1:0] rsp_cout_q;
   logic [WIDTH-1:0] rsp_sum_q [N_REQ];
   logic [WIDTH-1:0] add_a_q;
   logic [WIDTH-1:0] add_b_q;
   logic             add_cin_q;

   logic [WIDTH-1:0] op_a [N_REQ];
   logic [WIDTH-1:0] op_b [N_REQ];
   logic [N_REQ-1:0] eligible;
   logic             grant_found;
   logic [IDXW-1:0]  grant_idx;
   logic [IDXW-1:0]  cand;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_lane
         assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
         assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
         assign rsp_sum[gi*WIDTH +: WIDTH] = rsp_sum_q[gi];
      end
   endgenerate

   // A requester holding an unconsumed result is skipped, so capture never collides with clear.
   assign eligible = req_valid & ~rsp_valid_q;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ptr_q + IDXW'(k);
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && (state_q == IDLE) && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      if (state_q == BUSY) begin
         rsp_valid_d[owner_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         rsp_valid_q <= '0;
         rsp_cout_q  <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            rsp_sum_q[i] <= '0;
         end
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_cin_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         case (state_q)
            IDLE: begin
               if (grant_found) begin
                  add_a_q   <= op_a[grant_idx];
                  add_b_q   <= op_b[grant_idx];
                  add_cin_q <= req_cin[grant_idx];
                  owner_q   <= grant_idx;
                  state_q   <= BUSY;
               end
            end
            BUSY: begin
               // The adder has had the whole BUSY cycle to settle from the operand registers.
               rsp_sum_q[owner_q]  <= add_s;
               rsp_cout_q[owner_q] <= add_cout;
               ptr_q               <= owner_q + IDXW'(1);
               state_q             <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_cout  = rsp_cout_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_cin   = add_cin_q;
   assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter with a behavioural adder on the add_* ports.
module tb_adder_share_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic [N-1:0]     req_cin;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     rsp_valid;
   logic [N*W-1:0]   rsp_sum;
   logic [N-1:0]     rsp_cout;
   logic [N-1:0]     rsp_ready;
   logic [W-1:0]     add_a;
   logic [W-1:0]     add_b;
   logic             add_cin;
   logic [W-1:0]     add_s;
   logic             add_cout;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int last_grant;

   adder_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_ready (rsp_ready),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_cout  (add_cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Stand-in for the attached carry-select adder.
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + (W+1)'(c);
   endfunction

   // First requester after 'last' in cyclic order that the model does not mark as skipped.
   function automatic int next_grant(input int last, input logic [N-1:0] skip);
      for (int k = 1; k <= N; k++) begin
         if (!skip[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      req_a[idx*W +: W] = a;
      req_b[idx*W +: W] = b;
      req_cin[idx]      = c;
   endtask

   task automatic do_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] exp_res;
      int         n;
      exp_res = ref_add(a, b, c);
      set_ops(idx, a, b, c);
      req_valid[idx] = 1'b1;
      #1;
      n = 0;
      while (req_ready == '0 && n < 20) begin
         step();
         n++;
      end
      check("op_grant", req_ready, 64'(1) << idx);
      last_grant = idx;
      step();
      req_valid[idx] = 1'b0;
      check("op_busy", busy, 1);
      check("op_ready_in_busy", req_ready, 0);
      check("op_add_a", add_a, a);
      check("op_add_b", add_b, b);
      check("op_add_cin", add_cin, c);
      step();
      check("op_rsp_valid", rsp_valid[idx], 1);
      check("op_result", {rsp_cout[idx], rsp_sum[idx*W +: W]}, exp_res);
      check("op_idle", busy, 0);
      rsp_ready[idx] = 1'b1;
      step();
      rsp_ready[idx] = 1'b0;
      check("op_rsp_clear", rsp_valid[idx], 0);
   endtask

   // All requesters valid; grants, spacing and results checked against a transaction-level model.
   task automatic traffic(input int cycles, input logic [N-1:0] rr, input int release_at);
      logic [N-1:0] pend;
      logic [N-1:0] regen;
      logic [W:0]   exp_res [N];
      int           due [N];
      int           last_cyc;
      int           e;
      pend = '0;
      regen = '0;
      last_cyc = -1;
      rsp_ready = rr;
      for (int i = 0; i < N; i++) begin
         due[i] = -1;
         exp_res[i] = '0;
         set_ops(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      req_valid = '1;
      #1;
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < N; i++) begin
            if (due[i] == c) begin
               check("tr_rsp_valid", rsp_valid[i], 1);
               check("tr_result", {rsp_cout[i], rsp_sum[i*W +: W]}, exp_res[i]);
               due[i] = -1;
            end else if (pend[i] && due[i] < 0) begin
               check("bp_held_valid", rsp_valid[i], 1);
               check("bp_held_result", {rsp_cout[i], rsp_sum[i*W +: W]}, exp_res[i]);
            end
            if (regen[i]) set_ops(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
         end
         regen = '0;
         if (c == release_at + 1) check("bp_released", rsp_valid & ~rr, 0);
         if (req_ready != '0) begin
            e = next_grant(last_grant, pend);
            check("tr_grant", req_ready, 64'(1) << e);
            if (last_cyc >= 0) check("tr_accept_gap", 64'(c - last_cyc), 2);
            last_cyc = c;
            exp_res[e] = ref_add(req_a[e*W +: W], req_b[e*W +: W], req_cin[e]);
            due[e] = c + 2;
            regen[e] = 1'b1;
            last_grant = e;
            if (!rsp_ready[e]) pend[e] = 1'b1;
         end
         if (c == release_at) begin
            rsp_ready = '1;
            pend = '0;
         end
         step();
      end
      req_valid = '0;
      rsp_ready = '1;
      repeat (4) step();
      rsp_ready = '0;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      req_cin = '0;
      rsp_ready = '0;
      last_grant = N - 1;
      repeat (2) @(negedge clk);
      req_valid = 4'b0001;
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_sum", rsp_sum, 0);
      check("rst_rsp_cout", rsp_cout, 0);
      check("rst_add_a", add_a, 0);
      check("rst_add_cin", add_cin, 0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      #1;

      do_op(0, 32'd5, 32'd7, 1'b0);
      check("single_sum_kept", rsp_sum[0 +: W], 12);
      check("single_cout_kept", rsp_cout[0], 0);

      do_op(1, 32'hFFFF_FFFF, 32'd1, 1'b1);
      check("ovf_sum", rsp_sum[W +: W], 1);
      check("ovf_cout", rsp_cout[1], 1);
      do_op(1, 32'd0, 32'd0, 1'b1);
      check("zero_cin_sum", rsp_sum[W +: W], 1);
      check("zero_cin_cout", rsp_cout[1], 0);

      do_op(2, $urandom | 32'd1, $urandom, 1'b0);
      set_ops(2, 32'hA5A5_0001, 32'h0000_1234, 1'b1);
      req_valid[2] = 1'b1;
      #1;
      check("mid_grant", req_ready, 4'b0100);
      step();
      check("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_add_a", add_a, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_req_ready", req_ready, 0);
      step();
      rst = 1'b0;
      req_valid = '0;
      last_grant = N - 1;
      step();
      check("mid_no_result", rsp_valid, 0);

      traffic(24, 4'b1111, -1);
      traffic(40, 4'b1011, 24);

      for (int i = 0; i < N; i++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               for (int c = 0; c < 2; c++) begin
                  do_op(i, W'(a), W'(b), 1'(c));
               end
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Shares one combinational 32-bit carry-select adder between up to N_REQ requesters. Arbitrates round-robin, drives the operands into the adder from registers and captures the sum and carry into a per-requester response register. Sits between the requesting blocks and a single `carry_select_adder` instance, which is wired to the `add_*` ports.

## Interface
- N_REQ, 4: number of requesters; power of two, 2..8.
- WIDTH, 32: operand width; must match the attached adder.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  request i presents operands.
- req_a  in  N_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B; same packing.
- req_cin  in  N_REQ  carry-in per requester.
- req_ready  out  N_REQ  one-hot-or-zero; accept strobe for request i.
- rsp_valid  out  N_REQ  result held for requester i.
- rsp_sum  out  N_REQ*WIDTH  registered sum per requester.
- rsp_cout  out  N_REQ  registered carry-out per requester.
- rsp_ready  in  N_REQ  requester i consumes its result.
- add_a, add_b  out  WIDTH  registered operands to the adder.
- add_cin  out  1  registered carry-in to the adder.
- add_s  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out.
- busy  out  1  high in state BUSY.

## Operation
- FSM with two states: IDLE and BUSY.
- eligible[i] = req_valid[i] & ~rsp_valid[i]. This uses the registered rsp_valid.
- IDLE: if any request is eligible, grant the first eligible index, searching from ptr upward with wrap. req_ready[grant] = 1 combinationally; all other bits are 0. req_ready is always 0 in BUSY.
- Accept edge (IDLE with a grant):
  - add_a, add_b and add_cin load the granted operands.
  - owner is set to grant.
  - The FSM moves to BUSY.
- BUSY edge:
  - rsp_sum[owner] loads add_s.
  - rsp_cout[owner] loads add_cout.
  - rsp_valid[owner] is set.
  - ptr becomes (owner+1) mod N_REQ.
  - The FSM returns to IDLE.
- add_* outputs hold their last values after capture. They do not change until the next accept.
- rsp_valid[i] clears on the edge where rsp_ready[i] & rsp_valid[i].
  - rsp_sum and rsp_cout keep their values after the clear.
  - rsp_ready with rsp_valid = 0 is ignored.
- Arithmetic: {rsp_cout, rsp_sum} = A + B + cin, computed at WIDTH+1 bits. Overflow is reported only through rsp_cout.
- A requester with a pending result is skipped, so capture and clear of the same index can never collide. Clears and captures of different indices happen in the same edge independently.
- A requester that consumes its result in cycle C becomes eligible again from cycle C+1.
- Requesters must hold req_valid and their operands stable until req_ready is seen. The block does not check this.

## Timing
- Reset (async assert, sync-free release):
  - state = IDLE, ptr = 0, owner = 0.
  - rsp_valid = 0, rsp_sum = 0, rsp_cout = 0.
  - add_a = 0, add_b = 0, add_cin = 0.
  - busy = 0, req_ready = 0 while rst is high.
- Reset during BUSY discards the in-flight operation. No rsp_valid is raised.
- Latency: accept at edge T, rsp_valid high after edge T+1.
- Throughput: one operation per 2 cycles. No back-to-back accepts.
- The adder has exactly one full cycle (the BUSY cycle) to settle. Its path is add_a/add_b/add_cin register -> adder -> rsp register.
- Fairness: after requester i is served, every other continuously eligible requester is granted before i again. Worst-case wait is 2*(N_REQ-1) cycles plus the time spent waiting on its own rsp_ready.

## Test plan
- Single requester: req 0 presents A=5, B=7, cin=0.
  - req_ready[0] is high in the first IDLE cycle.
  - Two edges later, rsp_valid[0]=1, rsp_sum[0]=12, rsp_cout[0]=0.
  - Pulse rsp_ready[0] -> rsp_valid[0] clears next edge.
- Overflow: A=32'hFFFF_FFFF, B=1, cin=1 -> rsp_sum=1, rsp_cout=1. Then A=B=0, cin=1 -> rsp_sum=1, rsp_cout=0.
- Round-robin: all 4 requesters valid continuously, with rsp_ready tied high.
  - Grant order is 0, 1, 2, 3, 0, with an accept every 2 cycles.
  - Each result matches its own operands.
- Backpressure: hold rsp_ready[2]=0 with requester 2 valid.
  - After its first result, requester 2 is never granted while the others proceed.
  - Raising rsp_ready[2] makes it eligible the following cycle.
- Reset mid-operation: assert rst in BUSY.
  - All rsp_valid = 0, add_a = 0, busy = 0 immediately (asynchronously).
  - After release, the first grant starts from ptr 0.
- Exhaustive: per requester, A,B in 0..15 with cin in {0,1}.
  - Check {rsp_cout, rsp_sum} == A+B+cin.
  - Error count must be 0.
